// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Multi-cycle unsigned restoring divider that retires one quotient bit per
//   clock. The result word feeds the HI/LO register: remainder in the upper
//   half (HI) and quotient in the lower half (LO).
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-low reset (0 = reset)
//   start        division request, sampled only while idle
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   busy         high from the accepting edge until done rises
//   done         one-cycle pulse; divAns / div_by_zero are valid
//   divAns       {remainder, quotient}; held until the next result or reset
//   div_by_zero  raised with done when the captured divisor was zero
// -----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   divAns,
    output logic                 div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     rem_q,   rem_d;
    logic [WIDTH-1:0]     quo_q,   quo_d;
    logic [WIDTH-1:0]     dsr_q,   dsr_d;
    logic [CW-1:0]        cnt_q,   cnt_d;
    logic                 busy_q,  busy_d;
    logic                 done_q,  done_d;
    logic                 dbz_q,   dbz_d;
    logic [2*WIDTH-1:0]   ans_q,   ans_d;

    // One restoring step. The partial remainder never reaches the divisor,
    // so it fits in WIDTH bits; shifting in the next dividend bit needs
    // WIDTH+1 bits, which is the width of the trial subtraction.
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     rem_step;
    logic [WIDTH-1:0]     quo_step;

    always_comb begin
        trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};
        // A negative trial implies rem_q[WIDTH-1] was 0, so dropping it
        // in the restore path loses nothing.
        rem_step = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]}
                                : trial[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        ans_d   = ans_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        rem_d   = '0;
                        quo_d   = dividend;
                        dsr_d   = divisor;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        // Divide by zero: report remainder = dividend and an
                        // all-ones quotient without iterating.
                        ans_d   = {dividend, {WIDTH{1'b1}}};
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
                end
            end

            RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    ans_d   = {rem_step, quo_step};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ans_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ans_q   <= ans_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign divAns      = ans_q;
    assign div_by_zero = dbz_q;

endmodule
